udp_payload_packetizer: RTL and testbench

//  Upstream stage of the GMII UDP transmitter. Buffers a byte stream (e.g. ADC samples) in an on-chip FIFO.

---
 rtl/udp_payload_packetizer.sv | 194 +++++++++++++++++++
 tb/tb_udp_payload_packetizer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_payload_packetizer.sv
// udp_payload_packetizer
//   Front end of the GMII UDP transmitter. Buffers an incoming byte stream
//   in an on-chip FIFO, decides when a frame goes out (a full PKT_LEN
//   buffer, or a partial buffer that has sat idle for TIMEOUT_CYC), pulses
//   the UDP TX engine with the frame length, then serves payload bytes
//   first-word-fall-through on the engine's request strobe.
//
// Ports
//   clk125m        in   system / GMII clock
//   reset_p        in   asynchronous reset, active-high
//   din_valid      in   input byte valid
//   din[7:0]       in   input byte
//   din_ready      out  FIFO can accept a byte this cycle
//   tx_en_pulse_o  out  one-cycle frame start to the UDP TX engine
//   data_length_o  out  payload length of the current frame
//   payload_req_i  in   engine consumes one payload byte this cycle
//   payload_dat_o  out  current payload byte (valid with payload_req_i)
//   tx_done_i      in   one-cycle frame-complete pulse from the engine
//   busy_o         out  a frame is in flight (START..GAP)
//   overflow_o     out  sticky: byte offered while din_ready was low
//   underrun_o     out  sticky: request seen with no byte owed to the frame
module udp_payload_packetizer #(
  parameter int PKT_LEN     = 1024,
  parameter int AW          = 12,
  parameter int TIMEOUT_CYC = 125000,
  parameter int IFG_CYC     = 16
) (
  input  logic        clk125m,
  input  logic        reset_p,
  input  logic        din_valid,
  input  logic [7:0]  din,
  output logic        din_ready,
  output logic        tx_en_pulse_o,
  output logic [15:0] data_length_o,
  input  logic        payload_req_i,
  output logic [7:0]  payload_dat_o,
  input  logic        tx_done_i,
  output logic        busy_o,
  output logic        overflow_o,
  output logic        underrun_o
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] DEPTH_F   = (AW + 1)'(DEPTH);
  localparam logic [AW:0] PKT_LEN_F = (AW + 1)'(PKT_LEN);

  typedef enum logic [2:0] {
    IDLE,
    PREFETCH1,
    PREFETCH2,
    START,
    SEND,
    GAP
  } state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_nxt;
  logic [AW:0]   fill;
  logic [31:0]   timer;
  logic [31:0]   gap_cnt;
  logic [15:0]   owed;
  logic          wr_en;
  logic          pop;
  logic          full_trig;
  logic          time_trig;

  // fill is one bit wider than the pointers so "full" is distinguishable from
  // "empty"; a pop only happens while bytes are still owed to the frame.
  assign din_ready  = (fill < DEPTH_F);
  assign wr_en      = din_valid & din_ready;
  assign pop        = (state == SEND) & payload_req_i & (owed != 16'd0);
  assign rd_ptr_nxt = rd_ptr + AW'(1);
  assign full_trig  = (fill >= PKT_LEN_F);
  assign time_trig  = (TIMEOUT_CYC != 0) && (fill != '0) &&
                      (timer == 32'(TIMEOUT_CYC));

  // Byte storage; no reset so it maps onto block RAM.
  always_ff @(posedge clk125m) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, fill level, overflow flag and the idle timer. The timer only
  // runs while a partial buffer is waiting in IDLE with no new writes.
  always_ff @(posedge clk125m or posedge reset_p) begin
    if (reset_p) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      timer      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr_nxt;
      end
      case ({wr_en, pop})
        2'b10:   fill <= fill + (AW + 1)'(1);
        2'b01:   fill <= fill - (AW + 1)'(1);
        default: fill <= fill;
      endcase
      if (din_valid && !din_ready) begin
        overflow_o <= 1'b1;
      end
      if (wr_en || (fill == '0) || (state != IDLE)) begin
        timer <= '0;
      end else if (timer != 32'(TIMEOUT_CYC)) begin
        timer <= timer + 32'd1;
      end
    end
  end

  // Frame sequencer. payload_dat_o is the sync-read RAM output register:
  // PREFETCH loads the first byte, and each pop loads the following byte so
  // it is already presented on the next request. Once the last owed byte is
  // taken the register is zeroed, so extra requests see 8'h00.
  always_ff @(posedge clk125m or posedge reset_p) begin
    if (reset_p) begin
      state         <= IDLE;
      owed          <= '0;
      gap_cnt       <= '0;
      tx_en_pulse_o <= 1'b0;
      data_length_o <= '0;
      payload_dat_o <= '0;
      busy_o        <= 1'b0;
      underrun_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (full_trig) begin
            data_length_o <= 16'(PKT_LEN);
            owed          <= 16'(PKT_LEN);
            state         <= PREFETCH1;
          end else if (time_trig) begin
            data_length_o <= 16'(fill);
            owed          <= 16'(fill);
            state         <= PREFETCH1;
          end
        end
        PREFETCH1: begin
          payload_dat_o <= mem[rd_ptr];
          state         <= PREFETCH2;
        end
        PREFETCH2: begin
          payload_dat_o <= mem[rd_ptr];
          tx_en_pulse_o <= 1'b1;
          busy_o        <= 1'b1;
          state         <= START;
        end
        START: begin
          tx_en_pulse_o <= 1'b0;
          state         <= SEND;
        end
        SEND: begin
          if (payload_req_i) begin
            if (owed == 16'd0) begin
              underrun_o    <= 1'b1;
              payload_dat_o <= 8'h00;
            end else begin
              owed <= owed - 16'd1;
              if (owed == 16'd1) begin
                payload_dat_o <= 8'h00;
              end else begin
                payload_dat_o <= mem[rd_ptr_nxt];
              end
            end
          end
          if (tx_done_i) begin
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          if ((gap_cnt + 32'd1) >= 32'(IFG_CYC)) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 32'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_payload_packetizer.sv
// tb_udp_payload_packetizer
//   Directed bench for udp_payload_packetizer (PKT_LEN=16, 32-byte FIFO,
//   TIMEOUT_CYC=100, IFG_CYC=16) plus a second instance with flushing
//   disabled. Stimulus tasks push the expected payload bytes and frame
//   lengths into queues; a negedge monitor pops and compares them whenever
//   the DUT presents a request cycle or a frame-start pulse.
module tb_udp_payload_packetizer;

  localparam int PKT_LEN     = 16;
  localparam int AW          = 5;
  localparam int DEPTH       = 32;
  localparam int TIMEOUT_CYC = 100;
  localparam int IFG_CYC     = 16;

  logic        clk125m = 1'b0;
  logic        reset_p;
  logic        din_valid;
  logic [7:0]  din;
  logic        din_ready;
  logic        tx_en_pulse_o;
  logic [15:0] data_length_o;
  logic        payload_req_i;
  logic [7:0]  payload_dat_o;
  logic        tx_done_i;
  logic        busy_o;
  logic        overflow_o;
  logic        underrun_o;

  logic        nt_din_valid;
  logic [7:0]  nt_din;
  logic        nt_din_ready;
  logic        nt_tx_en_pulse;
  logic [15:0] nt_data_length;
  logic [7:0]  nt_payload_dat;
  logic        nt_busy;
  logic        nt_overflow;
  logic        nt_underrun;

  int checks = 0;
  int errors = 0;
  int model_owed = 0;
  int nt_pulses = 0;
  int n;
  logic [7:0]  model_fifo[$];
  logic [7:0]  exp_dat_q[$];
  logic [15:0] exp_len_q[$];

  udp_payload_packetizer #(
    .PKT_LEN(PKT_LEN), .AW(AW), .TIMEOUT_CYC(TIMEOUT_CYC), .IFG_CYC(IFG_CYC)
  ) dut (
    .clk125m(clk125m), .reset_p(reset_p), .din_valid(din_valid), .din(din),
    .din_ready(din_ready), .tx_en_pulse_o(tx_en_pulse_o),
    .data_length_o(data_length_o), .payload_req_i(payload_req_i),
    .payload_dat_o(payload_dat_o), .tx_done_i(tx_done_i), .busy_o(busy_o),
    .overflow_o(overflow_o), .underrun_o(underrun_o)
  );

  // Same block with flushing disabled: a partial buffer must never launch.
  udp_payload_packetizer #(
    .PKT_LEN(PKT_LEN), .AW(AW), .TIMEOUT_CYC(0), .IFG_CYC(IFG_CYC)
  ) dut_nt (
    .clk125m(clk125m), .reset_p(reset_p), .din_valid(nt_din_valid),
    .din(nt_din), .din_ready(nt_din_ready), .tx_en_pulse_o(nt_tx_en_pulse),
    .data_length_o(nt_data_length), .payload_req_i(1'b0),
    .payload_dat_o(nt_payload_dat), .tx_done_i(1'b0), .busy_o(nt_busy),
    .overflow_o(nt_overflow), .underrun_o(nt_underrun)
  );

  always #4 clk125m = ~clk125m;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Writes count consecutive byte values starting at first, one per cycle,
  // and records which ones the FIFO should accept.
  task automatic applyStimulus(input int count, input logic [7:0] first);
    logic [7:0] b;
    for (int i = 0; i < count; i++) begin
      b = first + 8'(i);
      din = b;
      din_valid = 1'b1;
      checkOutput("din_ready", din_ready, model_fifo.size() < DEPTH);
      if (model_fifo.size() < DEPTH) model_fifo.push_back(b);
      @(posedge clk125m); #1;
    end
    din_valid = 1'b0;
  endtask

  task automatic expectFrame(input int len);
    exp_len_q.push_back(16'(len));
    model_owed = len;
  endtask

  // Issues count request cycles; bytes beyond the frame length must read 0.
  task automatic requestBytes(input int count, input int chkFill);
    for (int i = 0; i < count; i++) begin
      payload_req_i = 1'b1;
      if (model_owed > 0) begin
        exp_dat_q.push_back(model_fifo.pop_front());
        model_owed--;
      end else begin
        exp_dat_q.push_back(8'h00);
      end
      @(posedge clk125m); #1;
      if (chkFill >= 0) checkOutput("fill_const", 32'(dut.fill), chkFill);
    end
    payload_req_i = 1'b0;
  endtask

  task automatic waitPulse(input int maxCycles, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < maxCycles) begin
      @(posedge clk125m); #1;
      cyc++;
      if (tx_en_pulse_o) seen = 1'b1;
    end
    checkOutput("pulse_seen", seen, 1);
  endtask

  task automatic doneFrame();
    tx_done_i = 1'b1;
    @(posedge clk125m); #1;
    tx_done_i = 1'b0;
    checkOutput("busy_in_gap", busy_o, 1);
  endtask

  task automatic waitIdle(input int maxCycles);
    int c;
    c = 0;
    while (busy_o && c < maxCycles) begin
      @(posedge clk125m); #1;
      c++;
    end
    checkOutput("busy_clear", busy_o, 0);
  endtask

  // Scoreboard monitor: compares every request cycle and frame start.
  always @(negedge clk125m) begin
    if (!reset_p) begin
      if (payload_req_i) begin
        if (exp_dat_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL payload_dat: got 0x%0h, expected no request", payload_dat_o);
        end else begin
          checkOutput("payload_dat", payload_dat_o, exp_dat_q.pop_front());
        end
      end
      if (tx_en_pulse_o) begin
        if (exp_len_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL data_length: got 0x%0h, expected no frame", data_length_o);
        end else begin
          checkOutput("data_length", data_length_o, exp_len_q.pop_front());
        end
        checkOutput("busy_at_start", busy_o, 1);
      end
      if (nt_tx_en_pulse) nt_pulses++;
    end
  end

  // Flush-disabled instance: five bytes that must stay put forever.
  initial begin
    nt_din_valid = 1'b0;
    nt_din = 8'h00;
    @(negedge reset_p);
    @(posedge clk125m); #1;
    for (int i = 0; i < 5; i++) begin
      nt_din_valid = 1'b1;
      nt_din = 8'(8'h70 + i);
      @(posedge clk125m); #1;
    end
    nt_din_valid = 1'b0;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_p = 1'b1;
    din_valid = 1'b0;
    din = 8'h00;
    payload_req_i = 1'b0;
    tx_done_i = 1'b0;
    @(posedge clk125m); @(posedge clk125m); #1;
    checkOutput("rst_din_ready", din_ready, 1);
    checkOutput("rst_tx_en", tx_en_pulse_o, 0);
    checkOutput("rst_length", data_length_o, 0);
    checkOutput("rst_dat", payload_dat_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_overflow", overflow_o, 0);
    checkOutput("rst_underrun", underrun_o, 0);
    reset_p = 1'b0;
    @(posedge clk125m); #1;

    // Full frame, then one request too many.
    expectFrame(16);
    applyStimulus(16, 8'h00);
    waitPulse(10, n);
    checkOutput("latency_full", n, 3);
    @(posedge clk125m); #1;
    requestBytes(16, -1);
    checkOutput("fill_after_a", 32'(dut.fill), 0);
    requestBytes(1, -1);
    checkOutput("underrun_set", underrun_o, 1);
    checkOutput("fill_after_underrun", 32'(dut.fill), 0);
    doneFrame();
    waitIdle(40);

    // Writes streaming in while the frame drains; next frame respects IFG.
    expectFrame(16);
    applyStimulus(16, 8'h20);
    waitPulse(10, n);
    checkOutput("latency_b", n, 3);
    @(posedge clk125m); #1;
    fork
      applyStimulus(16, 8'h30);
      requestBytes(16, 16);
    join
    doneFrame();
    expectFrame(16);
    waitPulse(60, n);
    checkOutput("ifg_min", n >= IFG_CYC, 1);
    checkOutput("ifg_max", n <= IFG_CYC + 4, 1);
    @(posedge clk125m); #1;
    requestBytes(16, -1);
    doneFrame();
    waitIdle(40);

    // Partial buffer flushed by the idle timer.
    expectFrame(5);
    applyStimulus(5, 8'h50);
    waitPulse(200, n);
    checkOutput("latency_timeout", n, TIMEOUT_CYC + 3);
    @(posedge clk125m); #1;
    requestBytes(5, -1);
    checkOutput("fill_after_d", 32'(dut.fill), 0);
    doneFrame();
    waitIdle(40);

    // Overfill: 40 bytes into 32 entries, no reads until done.
    expectFrame(16);
    applyStimulus(40, 8'h80);
    checkOutput("full_din_ready", din_ready, 0);
    checkOutput("overflow_set", overflow_o, 1);
    checkOutput("fill_full", 32'(dut.fill), DEPTH);
    requestBytes(16, -1);
    doneFrame();
    expectFrame(16);
    waitPulse(60, n);
    @(posedge clk125m); #1;
    requestBytes(16, -1);
    checkOutput("fill_after_f", 32'(dut.fill), 0);
    doneFrame();
    waitIdle(40);

    // Reset in the middle of SEND.
    expectFrame(16);
    applyStimulus(16, 8'hC0);
    waitPulse(10, n);
    @(posedge clk125m); #1;
    requestBytes(4, -1);
    reset_p = 1'b1;
    #1;
    checkOutput("mid_din_ready", din_ready, 1);
    checkOutput("mid_tx_en", tx_en_pulse_o, 0);
    checkOutput("mid_length", data_length_o, 0);
    checkOutput("mid_dat", payload_dat_o, 0);
    checkOutput("mid_busy", busy_o, 0);
    checkOutput("mid_overflow", overflow_o, 0);
    checkOutput("mid_underrun", underrun_o, 0);
    checkOutput("mid_fill", 32'(dut.fill), 0);
    model_fifo.delete();
    model_owed = 0;
    @(posedge clk125m); #1;
    reset_p = 1'b0;
    @(posedge clk125m); #1;

    // Clean frame after reset.
    expectFrame(16);
    applyStimulus(16, 8'hE0);
    waitPulse(10, n);
    checkOutput("latency_after_rst", n, 3);
    @(posedge clk125m); #1;
    requestBytes(16, -1);
    doneFrame();
    waitIdle(40);
    checkOutput("post_underrun", underrun_o, 0);
    checkOutput("post_overflow", overflow_o, 0);

    @(posedge clk125m); #1;
    checkOutput("exp_dat_left", exp_dat_q.size(), 0);
    checkOutput("exp_len_left", exp_len_q.size(), 0);
    checkOutput("nt_pulses", nt_pulses, 0);
    checkOutput("nt_busy", nt_busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
